// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and flag indices for alu_arbiter
package alu_pkg;

   // ALU select codes carried on req_op*/alu_sel
   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_MUL   = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_MOD   = 3'b100;
   localparam logic [2:0] OP_AND   = 3'b101;
   localparam logic [2:0] OP_OR    = 3'b110;
   localparam logic [2:0] OP_PASSB = 3'b111;

   // bit positions inside the {N,Z,V,C} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   // flags reported when a divide/modulo is refused for a zero divisor (Z and V)
   localparam logic [3:0] ZDIV_FLAGS = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // divide and modulo are the only ops that can be short-circuited
   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant, purely combinational
module rr_arb2
   import alu_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   // a lone requester always wins; on contention the pointer decides
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH       = 24,
   parameter int EXEC_CYCLES = 2
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [2:0]       req_op0,
   input  logic [2:0]       req_op1,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             alu_v,
   input  logic             alu_c,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             rsp_err
);

   // counter runs EXEC_CYCLES-1 down to 0, so EXEC lasts exactly EXEC_CYCLES cycles
   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   state_t           state;
   logic             ptr;
   logic [3:0]       cnt;
   logic [1:0]       grant;
   logic             gnt_id;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             in_zdiv;

   rr_arb2 u_arb (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   assign gnt_id = grant[1];

   // operand set of whichever requester the arbiter picked this cycle
   always_comb begin
      in_a  = gnt_id ? req_a1  : req_a0;
      in_b  = gnt_id ? req_b1  : req_b0;
      in_op = gnt_id ? req_op1 : req_op0;
   end

   assign in_zdiv = is_div_op(in_op) && (in_b == '0);

   // accept strobe only in IDLE; gated by rst_n so it drops the instant reset asserts
   assign req_ready = (rst_n && (state == ST_IDLE)) ? grant : 2'b00;

   // control FSM with registered ALU drive and response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= 1'b0;
         cnt        <= 4'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= 3'b000;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= 4'b0000;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  rsp_id <= gnt_id;
                  if (in_zdiv) begin
                     // zero divisor: answer directly, leave the ALU drive untouched
                     rsp_result <= '0;
                     rsp_flags  <= ZDIV_FLAGS;
                     rsp_err    <= 1'b1;
                     rsp_valid  <= 1'b1;
                     state      <= ST_RESP;
                  end else begin
                     alu_a   <= in_a;
                     alu_b   <= in_b;
                     alu_sel <= in_op;
                     cnt     <= CNT_LOAD;
                     state   <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (cnt == 4'd0) begin
                  rsp_result <= alu_out;
                  rsp_flags  <= {alu_n, alu_z, alu_v, alu_c};
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= ~rsp_id;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

   localparam int W    = 24;
   localparam int EXEC = 2;

   logic          clk;
   logic          rst_n;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
   logic [2:0]    req_op0, req_op1;
   logic [W-1:0]  alu_a, alu_b;
   logic [2:0]    alu_sel;
   logic [W-1:0]  alu_out;
   logic          alu_n, alu_z, alu_v, alu_c;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_id;
   logic [W-1:0]  rsp_result;
   logic [3:0]    rsp_flags;
   logic          rsp_err;

   int            tests = 0;
   int            fails = 0;
   bit            model_ptr;
   logic [W-1:0]  last_res;
   logic [3:0]    last_flags;
   logic          last_err;
   logic          last_id;

   alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(EXEC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a0     (req_a0),
      .req_b0     (req_b0),
      .req_a1     (req_a1),
      .req_b1     (req_b1),
      .req_op0    (req_op0),
      .req_op1    (req_op1),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .alu_n      (alu_n),
      .alu_z      (alu_z),
      .alu_v      (alu_v),
      .alu_c      (alu_c),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_err    (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // arithmetic behaviour of the external ALU: {N,Z,V,C,result}
   function automatic logic [27:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         v, c;
      v = 1'b0; c = 1'b0; r = '0; s = '0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd2: r = a * b;
         3'd3: r = (b != '0) ? a / b : '0;
         3'd4: r = (b != '0) ? a % b : '0;
         3'd5: r = a & b;
         3'd6: r = a | b;
         default: r = b;
      endcase
      return {r[W-1], (r == '0), v, c, r};
   endfunction

   // expected response for a request: {err, flags, result}
   function automatic logic [28:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      if ((op == 3'd3 || op == 3'd4) && b == '0)
         return {1'b1, 4'b0110, 24'h000000};
      return {1'b0, alu_fn(a, b, op)};
   endfunction

   always_comb {alu_n, alu_z, alu_v, alu_c, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      if (r == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
      else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
      req_valid[r] = 1'b1;
   endtask

   // called right after a negedge; returns the granted requester and cycles waited
   task automatic wait_grant(output int g, output int waited);
      g = -1; waited = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req_ready != 2'b00) begin
            g = req_ready[1] ? 1 : 0;
            waited = i;
            break;
         end
         @(negedge clk);
      end
      if (g < 0) begin
         tests++; fails++;
         $error("FAIL grant_timeout observed=none expected=grant within 20 cycles");
         g = 0;
      end
   endtask

   // follows one accepted request through to its response handshake
   task automatic finish_rsp(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] op, input int stall, input bit drop_all);
      logic [28:0]  e;
      int           lat;
      e = model(a, b, op);
      chk("gnt_onehot", req_ready, (g == 1) ? 2'b10 : 2'b01);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1 && drop_all) req_valid = 2'b00;
         #1;
         if (rsp_valid) begin lat = i; break; end
         chk("ready_while_busy", req_ready, 2'b00);
      end
      chk("latency", lat, e[28] ? 1 : EXEC + 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_result", rsp_result, e[23:0]);
      chk("rsp_flags", rsp_flags, e[27:24]);
      chk("rsp_err", rsp_err, e[28]);
      last_res = rsp_result; last_flags = rsp_flags; last_err = rsp_err; last_id = rsp_id;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (drop_all && s == 0) req_valid[1-g] = 1'b1;
         #1;
         chk("stall_valid", rsp_valid, 1'b1);
         chk("stall_result", rsp_result, e[23:0]);
         chk("stall_flags", rsp_flags, e[27:24]);
         chk("stall_id", rsp_id, g);
         chk("stall_no_ready", req_ready, 2'b00);
      end
      if (drop_all) req_valid = 2'b00;
      rsp_ready = 1'b1;
      #1;
      chk("hs_no_ready", req_ready, 2'b00);
      @(negedge clk);
      rsp_ready = 1'b0;
      model_ptr = (g == 0);
      #1;
      chk("rsp_released", rsp_valid, 1'b0);
      if (drop_all) chk("dropped_req_ignored", req_ready, 2'b00);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 2'b00);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_id"}, rsp_id, 1'b0);
      chk({tag, "_rsp_result"}, rsp_result, 24'h0);
      chk({tag, "_rsp_flags"}, rsp_flags, 4'h0);
      chk({tag, "_rsp_err"}, rsp_err, 1'b0);
      chk({tag, "_alu_a"}, alu_a, 24'h0);
      chk({tag, "_alu_b"}, alu_b, 24'h0);
      chk({tag, "_alu_sel"}, alu_sel, 3'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           g, waited, mask, eg;
      logic [W-1:0] a0, b0, a1, b1, ga, gb, sa, sb;
      logic [2:0]   op0, op1, gop, ss;

      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; model_ptr = 1'b0;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
      repeat (2) @(negedge clk);

      // request pending during reset must not be accepted
      drive(0, 24'd5, 24'd3, 3'b000);
      #1;
      chk_all_zero("reset");

      // first cycle out of reset grants immediately
      @(negedge clk);
      rst_n = 1'b1;
      wait_grant(g, waited);
      chk("first_grant_wait", waited, 0);
      chk("first_grant_id", g, 0);
      finish_rsp(g, 24'd5, 24'd3, 3'b000, 0, 1'b1);
      chk("add_result", last_res, 24'd8);
      chk("add_flags", last_flags, 4'b0000);
      chk("add_id", last_id, 1'b0);

      // signed overflow into the sign bit
      drive(0, 24'h7FFFFF, 24'h000001, 3'b000);
      wait_grant(g, waited);
      finish_rsp(g, 24'h7FFFFF, 24'h000001, 3'b000, 0, 1'b1);
      chk("ovf_result", last_res, 24'h800000);
      chk("ovf_flags", last_flags, 4'b1010);

      // zero result, response stalled while the other requester pokes
      drive(0, 24'h000001, 24'h000001, 3'b001);
      wait_grant(g, waited);
      finish_rsp(g, 24'h000001, 24'h000001, 3'b001, 5, 1'b1);
      chk("sub_zero_result", last_res, 24'h0);
      chk("sub_zero_flags", last_flags, 4'b0100);

      // divide by zero short-circuits and leaves the ALU drive alone
      sa = alu_a; sb = alu_b; ss = alu_sel;
      drive(1, 24'd7, 24'd0, 3'b011);
      wait_grant(g, waited);
      chk("zdiv_grant", g, 1);
      finish_rsp(g, 24'd7, 24'd0, 3'b011, 0, 1'b1);
      chk("zdiv_result", last_res, 24'h0);
      chk("zdiv_flags", last_flags, 4'b0110);
      chk("zdiv_err", last_err, 1'b1);
      chk("zdiv_alu_a", alu_a, sa);
      chk("zdiv_alu_b", alu_b, sb);
      chk("zdiv_alu_sel", alu_sel, ss);

      // fresh reset, then both requesters held valid: grants must alternate
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_ptr = 1'b0;
      a0 = 24'($urandom); b0 = 24'($urandom); a1 = 24'($urandom); b1 = 24'($urandom);
      drive(0, a0, b0, 3'b001);
      drive(1, a1, b1, 3'b001);
      for (int k = 0; k < 4; k++) begin
         wait_grant(g, waited);
         chk("alt_grant", g, k % 2);
         chk("alt_grant_ptr", g, model_ptr);
         finish_rsp(g, g ? a1 : a0, g ? b1 : b0, 3'b001, 0, 1'b0);
         chk("alt_rsp_id", last_id, k % 2);
      end
      req_valid = 2'b00;

      // reset in the middle of EXEC
      a0 = 24'($urandom) | 24'h1; b0 = 24'($urandom) | 24'h1;
      @(negedge clk);
      drive(0, a0, b0, 3'b000);
      wait_grant(g, waited);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("exec_alu_a_loaded", alu_a, a0);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midexec_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_ptr = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         chk("no_stale_rsp", rsp_valid, 1'b0);
      end

      // rsp_ready with nothing pending is ignored
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("idle_rsp_ready", rsp_valid, 1'b0);
      end
      rsp_ready = 1'b0;

      // randomized traffic against the reference model
      for (int n = 0; n < 24; n++) begin
         mask = $urandom_range(1, 3);
         op0 = 3'($urandom); op1 = 3'($urandom);
         a0 = 24'($urandom); a1 = 24'($urandom);
         b0 = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
         b1 = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
         @(negedge clk);
         if (mask[0]) drive(0, a0, b0, op0);
         if (mask[1]) drive(1, a1, b1, op1);
         eg = (mask == 1) ? 0 : (mask == 2) ? 1 : int'(model_ptr);
         wait_grant(g, waited);
         chk("rand_grant", g, eg);
         ga = g ? a1 : a0; gb = g ? b1 : b0; gop = g ? op1 : op0;
         finish_rsp(g, ga, gb, gop, $urandom_range(0, 3), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
